// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared memory port: CPU (req0) and loader (req1).
// Rejects out-of-range addresses and CPU writes into the instruction region.
module mem_port_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_SIZE    = 130,
  parameter int INSTR_WORDS = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LP_MEM = ADDR_W'(MEM_SIZE);
  localparam logic [ADDR_W-1:0] LP_INS = ADDR_W'(INSTR_WORDS);

  typedef enum logic {S_IDLE, S_ACC} state_t;

  state_t            r_state;
  logic              r_last;
  logic              r_id;
  logic              r_err;
  logic              r_gnt0, r_gnt1;
  logic              r_done0, r_done1;
  logic              r_err0, r_err1;
  logic [DATA_W-1:0] r_rdata0, r_rdata1;
  logic              r_mem_read, r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_busy;

  logic              w_pick1;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_err;

  // On a tie the requester that did not win last time goes first
  always_comb begin
    w_pick1 = req1 & (~req0 | ~r_last);
    w_we    = w_pick1 ? we1 : we0;
    w_addr  = w_pick1 ? addr1 : addr0;
    w_wdata = w_pick1 ? wdata1 : wdata0;
    w_err   = (w_addr >= LP_MEM) |
              (~w_pick1 & w_we & (w_addr < LP_INS));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_id        <= 1'b0;
      r_err       <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_err0  <= 1'b0;
      r_err1  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req0 | req1) begin
            r_state     <= S_ACC;
            r_id        <= w_pick1;
            r_last      <= w_pick1;
            r_err       <= w_err;
            r_gnt0      <= ~w_pick1;
            r_gnt1      <= w_pick1;
            r_busy      <= 1'b1;
            r_mem_read  <= ~w_we & ~w_err;
            r_mem_write <= w_we & ~w_err;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_wdata;
          end
        end
        S_ACC: begin
          r_state     <= S_IDLE;
          r_gnt0      <= 1'b0;
          r_gnt1      <= 1'b0;
          r_busy      <= 1'b0;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
          if (r_id) begin
            r_done1  <= 1'b1;
            r_err1   <= r_err;
            r_rdata1 <= r_mem_read ? mem_rdata : '0;
          end else begin
            r_done0  <= 1'b1;
            r_err0   <= r_err;
            r_rdata0 <= r_mem_read ? mem_rdata : '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign done0     = r_done0;
  assign done1     = r_done1;
  assign err0      = r_err0;
  assign err1      = r_err1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 130-word memory model.
// Each task drives one scenario and checks hand-computed values.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [15:0] rdata0, rdata1;
  logic        mem_read, mem_write;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  logic [15:0] mem [0:129];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < 16'd130) ? mem[mem_addr[7:0]] : 16'h0;

  always @(posedge clk)
    if (mem_write && mem_addr < 16'd130)
      mem[mem_addr[7:0]] <= mem_wdata;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit id, input logic we,
                       input logic [15:0] a, input logic [15:0] d);
    if (id) begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end
  endtask

  task automatic drop();
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic test_reset();
    logic [74:0] obs;
    reset  = 1'b1;
    req0   = 1'($urandom);
    req1   = 1'($urandom);
    we0    = 1'($urandom);
    we1    = 1'($urandom);
    addr0  = 16'($urandom);
    addr1  = 16'($urandom);
    wdata0 = 16'($urandom);
    wdata1 = 16'($urandom);
    step();
    step();
    obs = {gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
           mem_read, mem_write, mem_addr, mem_wdata, busy};
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    we0 = 1'b0; we1 = 1'b0; addr0 = 16'd0; addr1 = 16'd1;
    req0 = 1'b1; req1 = 1'b1;
    reset = 1'b0;
    step();
    n_checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_first_tie: got %b expected 10", {gnt0, gnt1});
    end
    drop();
    step();
    step();
  endtask

  task automatic test_read();
    mem[105] <= 16'h1234;
    issue(1'b0, 1'b0, 16'd105, 16'h0);
    step();
    n_checks++;
    if ({gnt0, gnt1, mem_read, mem_write, busy, mem_addr} !==
        {5'b10101, 16'd105}) begin
      n_fail++;
      $display("FAIL read_acc: got %b%b%b%b%b %0d expected 10101 105",
               gnt0, gnt1, mem_read, mem_write, busy, mem_addr);
    end
    drop();
    step();
    n_checks++;
    if ({done0, done1, err0, rdata0} !== {3'b100, 16'h1234}) begin
      n_fail++;
      $display("FAIL read_done: got %b%b%b %h expected 100 1234",
               done0, done1, err0, rdata0);
    end
    step();
  endtask

  task automatic test_contention();
    logic [3:0] exp;
    // last winner was requester 0, so requester 1 leads
    issue(1'b0, 1'b0, 16'd1, 16'h0);
    issue(1'b1, 1'b0, 16'd2, 16'h0);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k % 2 == 1)
        exp = (((k - 1) / 2) % 2 == 0) ? 4'b0100 : 4'b1000;
      else
        exp = (((k - 2) / 2) % 2 == 0) ? 4'b0001 : 4'b0010;
      n_checks++;
      if ({gnt0, gnt1, done0, done1} !== exp) begin
        n_fail++;
        $display("FAIL contention_cyc%0d: got %b expected %b",
                 k, {gnt0, gnt1, done0, done1}, exp);
      end
    end
    drop();
    step();
    n_checks++;
    if ({busy, gnt0, gnt1} !== 3'b000) begin
      n_fail++;
      $display("FAIL contention_idle: got %b expected 000", {busy, gnt0, gnt1});
    end
  endtask

  task automatic test_protection();
    issue(1'b0, 1'b1, 16'd10, 16'hBEEF);
    step();
    n_checks++;
    if ({gnt0, mem_write, mem_read} !== 3'b100) begin
      n_fail++;
      $display("FAIL prot_cpu_acc: got %b expected 100",
               {gnt0, mem_write, mem_read});
    end
    drop();
    step();
    n_checks++;
    if ({done0, err0, rdata0, mem_write} !== {2'b11, 16'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL prot_cpu_done: got %b%b %h %b expected 11 0000 0",
               done0, err0, rdata0, mem_write);
    end
    n_checks++;
    if (mem[10] !== 16'd10) begin
      n_fail++;
      $display("FAIL prot_cpu_mem: got %h expected 000a", mem[10]);
    end
    issue(1'b1, 1'b1, 16'd10, 16'hBEEF);
    step();
    n_checks++;
    if ({gnt1, mem_write, mem_read, mem_addr, mem_wdata} !==
        {3'b110, 16'd10, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL prot_ldr_acc: got %b%b%b %h %h expected 110 000a beef",
               gnt1, mem_write, mem_read, mem_addr, mem_wdata);
    end
    drop();
    step();
    n_checks++;
    if ({done1, err1, rdata1} !== {2'b10, 16'h0}) begin
      n_fail++;
      $display("FAIL prot_ldr_done: got %b%b %h expected 10 0000",
               done1, err1, rdata1);
    end
    n_checks++;
    if (mem[10] !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL prot_ldr_mem: got %h expected beef", mem[10]);
    end
    step();
  endtask

  task automatic test_range();
    issue(1'b1, 1'b0, 16'd129, 16'h0);
    step();
    drop();
    step();
    n_checks++;
    if ({done1, err1, rdata1} !== {2'b10, 16'd129}) begin
      n_fail++;
      $display("FAIL range_129: got %b%b %h expected 10 0081",
               done1, err1, rdata1);
    end
    step();
    n_checks++;
    if ({done1, rdata1} !== {1'b0, 16'd129}) begin
      n_fail++;
      $display("FAIL range_hold: got %b %h expected 0 0081", done1, rdata1);
    end
    issue(1'b1, 1'b0, 16'd130, 16'h0);
    step();
    n_checks++;
    if ({gnt1, mem_read, mem_write} !== 3'b100) begin
      n_fail++;
      $display("FAIL range_130_acc: got %b expected 100",
               {gnt1, mem_read, mem_write});
    end
    drop();
    step();
    n_checks++;
    if ({done1, err1, rdata1} !== {2'b11, 16'h0}) begin
      n_fail++;
      $display("FAIL range_130_done: got %b%b %h expected 11 0000",
               done1, err1, rdata1);
    end
    step();
    n_checks++;
    if ({err1, done1} !== 2'b00) begin
      n_fail++;
      $display("FAIL range_err_clear: got %b expected 00", {err1, done1});
    end
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 1'b1, 16'd120, 16'hCAFE);
    step();
    n_checks++;
    if ({gnt1, mem_write} !== 2'b11) begin
      n_fail++;
      $display("FAIL rmid_acc: got %b expected 11", {gnt1, mem_write});
    end
    drop();
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({gnt1, mem_write, busy, mem_addr} !== {3'b000, 16'h0}) begin
      n_fail++;
      $display("FAIL rmid_async: got %b%b%b %h expected 000 0000",
               gnt1, mem_write, busy, mem_addr);
    end
    step();
    reset = 1'b0;
    step();
    n_checks++;
    if ({done1, mem[120]} !== {1'b0, 16'd120}) begin
      n_fail++;
      $display("FAIL rmid_nodone: got %b %h expected 0 0078", done1, mem[120]);
    end
    issue(1'b1, 1'b0, 16'd120, 16'h0);
    step();
    n_checks++;
    if ({gnt1, mem_read} !== 2'b11) begin
      n_fail++;
      $display("FAIL rmid_after_acc: got %b expected 11", {gnt1, mem_read});
    end
    drop();
    step();
    n_checks++;
    if ({done1, err1, rdata1} !== {2'b10, 16'd120}) begin
      n_fail++;
      $display("FAIL rmid_after_done: got %b%b %h expected 10 0078",
               done1, err1, rdata1);
    end
    step();
  endtask

  initial begin
    for (int i = 0; i < 130; i++) mem[i] <= 16'(i);
    test_reset();
    test_read();
    test_contention();
    test_protection();
    test_range();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter for the single shared 16-bit memory port of the multi-cycle MIPS. It serialises accesses from the CPU datapath (requester 0) and the debug/loader port (requester 1) onto one memory read/write port, using round-robin arbitration. It rejects out-of-range addresses and CPU writes into the instruction region. It sits between both requesters and the 130-word memory; the memory read path is combinational and the memory write path is clocked.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_SIZE, 130, number of implemented words; addresses >= MEM_SIZE are illegal
- INSTR_WORDS, 100, words 0..INSTR_WORDS-1 form the instruction region; requester 0 must not write there

- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- req0 / req1  in  1  access request; hold high until the matching gnt
- we0 / we1  in  1  1 = write, 0 = read; hold stable until gnt
- addr0 / addr1  in  ADDR_W  word address; hold stable until gnt
- wdata0 / wdata1  in  DATA_W  write data; hold stable until gnt
- gnt0 / gnt1  out  1  one-cycle pulse; the request has been captured
- done0 / done1  out  1  one-cycle pulse; the access has completed
- err0 / err1  out  1  valid with done; 1 = access rejected
- rdata0 / rdata1  out  DATA_W  valid with done; read data, 0 on write or error
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  combinational memory read data
- busy  out  1  high while in ACC

## Operation
- State machine has two states: IDLE and ACC. Reset enters IDLE and sets last_grant = 1, so requester 0 wins the first tie.
- **IDLE**
  - If only one req is high, grant that requester.
  - If both are high, grant the requester != last_grant.
  - On the grant edge:
    - latch we/addr/wdata and the requester id;
    - compute the error flag;
    - set last_grant = id;
    - go to ACC.
  - If no req is high, stay in IDLE.
- **Error flag** is set if addr >= MEM_SIZE, or if id = 0, we = 1 and addr < INSTR_WORDS. Requester 1 may write anywhere below MEM_SIZE.
- **ACC** (exactly one cycle)
  - gnt[id] = 1 and busy = 1.
  - mem_addr = latched addr; mem_wdata = latched wdata.
  - mem_read = !we && !err; mem_write = we && !err.
  - On the exit edge: register rdata[id] = (read && !err) ? mem_rdata : 0, set err[id], pulse done[id], return to IDLE.
- With err = 1, neither memory strobe asserts in any cycle.
- In the cycle after ACC (IDLE with done high), new arbitration proceeds normally. Sustained throughput is one access per 2 cycles.
- A requester that still holds req high in its gnt cycle has posted a new request. That request is arbitrated in the following IDLE cycle.
- Outside ACC, mem_read = mem_write = 0 and mem_addr = mem_wdata = 0.
- rdata0/rdata1 hold their last value between done pulses. err0/err1 are 0 except in their done cycle.

## Timing
- Reset values: all gnt, done, err, rdata, mem_* and busy are 0; state = IDLE; last_grant = 1.
- Cycle-level sequence:
  - Cycle N: req sampled in IDLE.
  - Cycle N+1: ACC, with gnt pulse and memory strobes.
  - Cycle N+2: done, err and rdata valid.
- Memory write takes effect at the end of cycle N+1.
- Latency from request to done is 2 cycles. Back-to-back grants are 2 cycles apart.
- Reset asserted mid-ACC:
  - all outputs go to 0 immediately, without waiting for a clock edge;
  - no done is issued;
  - no memory write occurs unless the write edge already passed;
  - last_grant returns to 1.
- An address or we change while req is waiting (before gnt) is permitted. The value sampled on the grant edge is the one used.

## Test plan
- Reset: assert reset with random inputs -> all outputs 0. Release, drive req0 = 1 and req1 = 1 -> first gnt is gnt0.
- Read: mem[105] = 0x1234; req0 read addr 105 in cycle N -> cycle N+1 has gnt0 = 1, mem_read = 1, mem_addr = 105. Cycle N+2 has done0 = 1, err0 = 0, rdata0 = 0x1234.
- Contention: req0 and req1 held high continuously -> the sequence is gnt0, gnt1, gnt0, gnt1 with gnts 2 cycles apart. Each done follows its gnt by 1 cycle.
- Protection: req0 write addr 10 data 0xBEEF -> mem_write never asserts, done0 with err0 = 1, mem[10] unchanged. req1 write addr 10 data 0xBEEF -> mem_write = 1 in ACC, mem[10] = 0xBEEF, err1 = 0.
- Range: req1 read addr 130 -> mem_read stays 0, done1 with err1 = 1 and rdata1 = 0. Addr 129 reads normally.
- Reset mid-access: assert reset during the ACC of a req1 write to addr 120 -> mem_write drops immediately, no done1, mem[120] unchanged. A req1 access after reset release completes normally.
